pc_sequencer: RTL and testbench

Next-PC controller for the single-cycle RV32 core. Drives the PC register's input every cycle, selecting reset vector, hold, PC+4, jump/branch target or trap vector, and sequences instruction fetch through a ready-based instruction-memory handshake. It also implements a debug halt/resume and a retired-instruction counter. It sits between the PC register, instruction memory and the control/branch unit.

---
 rtl/pc_sequencer_pkg.sv | 25 ++
 rtl/pc_sequencer_pc_next_mux.sv | 39 +++
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 tb/tb_pc_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the next-PC sequencer: sequencer states,
// default vectors and instruction alignment helpers.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0010;

    // Byte distance between consecutive instructions.
    localparam logic [31:0] INSTR_ALIGN = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] force_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_pc_next_mux.sv
// Priority select of the PC for a committing instruction:
// halt_req > jmp > br_taken > sequential, with target alignment handling.
// TRAP_EN chooses between redirecting misaligned targets to TRAP_VEC and
// silently clearing the low address bits.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter bit          TRAP_EN  = 1'b0,
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
    input  logic [31:0] pc_i,
    input  logic        halt_req_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] commit_pc_o
);

    logic [31:0] seq_pc;
    logic [31:0] target;

    // Pick the redirect target and resolve the committing PC by priority.
    always_comb begin
        seq_pc      = pc_i + INSTR_ALIGN;
        target      = jmp_i ? jmp_target_i : br_target_i;
        commit_pc_o = seq_pc;
        if (halt_req_i) begin
            commit_pc_o = seq_pc;
        end else if (jmp_i || br_taken_i) begin
            if (TRAP_EN && is_misaligned(target)) begin
                commit_pc_o = TRAP_VEC;
            end else begin
                commit_pc_o = force_align(target);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: drives the PC register input, sequences instruction
// fetch over a ready handshake, supports debug halt/resume and counts
// retired instructions.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned jump/branch targets
// redirect to TRAP_VEC and report trap/epc; otherwise low bits are cleared).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] TRAP_VEC  = DEFAULT_TRAP_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        instr_valid,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted,
    output logic [31:0] retired
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        trap,
    output logic [31:0] epc
`endif
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    seq_state_t  state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] commit_pc;

    pc_next_mux #(
        .TRAP_EN  (TRAP_EN),
        .TRAP_VEC (TRAP_VEC)
    ) u_pc_next_mux (
        .pc_i         (pc),
        .halt_req_i   (halt_req),
        .jmp_i        (jmp),
        .jmp_target_i (jmp_target),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .commit_pc_o  (commit_pc)
    );

    // Sequencer state register; reset abandons any pending fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and fetch/PC outputs from current state and handshake.
    always_comb begin
        state_d     = state_q;
        pc_next     = pc;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                pc_next = RESET_VEC;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_valid = 1'b1;
                    pc_next     = commit_pc;
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign imem_addr = pc;
    assign halted    = (state_q == ST_HALT);

    // Retired counter advances once per committed instruction, wrapping.
    always_comb begin
        retired_d = retired_q;
        if (instr_valid) begin
            retired_d = retired_q + 32'd1;
        end
    end

    // Retired counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

`ifdef MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] epc_q;

    // A committing jump/branch whose target is misaligned raises a trap;
    // halt_req outranks the redirect so it never traps.
    always_comb begin
        trap_d = 1'b0;
        if (instr_valid && !halt_req) begin
            if (jmp) begin
                trap_d = is_misaligned(jmp_target);
            end else if (br_taken) begin
                trap_d = is_misaligned(br_target);
            end
        end
    end

    // Trap pulse and faulting PC capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_q <= 1'b0;
            epc_q  <= '0;
        end else begin
            trap_q <= trap_d;
            if (trap_d) begin
                epc_q <= pc;
            end
        end
    end

    assign trap = trap_q;
    assign epc  = epc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps from the test plan
// followed by randomized traffic, compared against a behavioural model.
// The bench also plays the role of the PC register.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0010;
    localparam int M_BOOT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HALT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_r;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        instr_valid;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic [31:0] retired;
`ifdef MISALIGN_TRAP_EN
    logic        trap;
    logic [31:0] epc;
`endif

    int          checks = 0;
    int          errors = 0;
    int          m_mode;
    logic [31:0] m_retired;
    logic        m_trap;
    logic [31:0] m_epc;

    pc_sequencer #(
        .RESET_VEC (RV),
        .TRAP_VEC  (TV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc_r),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .instr_valid (instr_valid),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt_req    (halt_req),
        .resume      (resume),
        .halted      (halted),
        .retired     (retired)
`ifdef MISALIGN_TRAP_EN
        ,
        .trap        (trap),
        .epc         (epc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        jmp = 1'b0; br_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
        jmp_target = '0; br_target = '0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".retired"}, retired, m_retired);
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_mode == M_HALT});
`ifdef MISALIGN_TRAP_EN
        chk({tag, ".trap"}, {31'd0, trap}, {31'd0, m_trap});
        chk({tag, ".epc"}, epc, m_epc);
`endif
    endtask

    // One clock cycle: called #1 after a rising edge with inputs applied.
    task automatic cycle(input string tag);
        logic [31:0] e_next;
        logic [31:0] tgt;
        logic        e_req, e_valid, e_trap;
        int          n_mode;
        #1;
        e_next = pc_r; e_req = 1'b0; e_valid = 1'b0; e_trap = 1'b0; n_mode = m_mode;
        if (m_mode == M_BOOT) begin
            e_next = RV;
            n_mode = M_FETCH;
        end else if (m_mode == M_FETCH) begin
            e_req = 1'b1;
            if (imem_ready) begin
                e_valid = 1'b1;
                if (halt_req) begin
                    e_next = pc_r + 32'd4;
                    n_mode = M_HALT;
                end else if (jmp || br_taken) begin
                    tgt = jmp ? jmp_target : br_target;
                    if (tgt % 4 != 0) begin
`ifdef MISALIGN_TRAP_EN
                        e_next = TV;
                        e_trap = 1'b1;
`else
                        e_next = tgt - (tgt % 4);
`endif
                    end else begin
                        e_next = tgt;
                    end
                end else begin
                    e_next = pc_r + 32'd4;
                end
            end
        end else if (resume) begin
            n_mode = M_FETCH;
        end
        chk({tag, ".pc_next"}, pc_next, e_next);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, ".imem_addr"}, imem_addr, pc_r);
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_mode == M_HALT});
        @(posedge clk);
        #1;
        if (e_trap) m_epc = pc_r;
        m_trap = e_trap;
        pc_r   = e_next;
        m_mode = n_mode;
        if (e_valid) m_retired = m_retired + 32'd1;
        chk_regs({tag, ".post"});
    endtask

    // Asynchronous reset pulse started #1 after a rising edge.
    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #1;
        m_mode = M_BOOT; m_retired = '0; m_trap = 1'b0; m_epc = '0;
        chk({tag, ".pc_next"}, pc_next, RV);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, 32'd0);
        chk_regs(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; imem_ready = 1'b1; pc_r = 32'hDEAD_BEE0;
        idle_inputs();
        m_mode = M_BOOT; m_retired = '0; m_trap = 1'b0; m_epc = '0;

        // Reset state
        #2;
        chk("rst.pc_next", pc_next, RV);
        chk("rst.imem_req", {31'd0, imem_req}, 32'd0);
        chk_regs("rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Boot then sequential fetch
        cycle("boot");
        cycle("seq0");
        cycle("seq4");

        // Stall at 0x8 for three cycles, then commit
        imem_ready = 1'b0;
        repeat (3) cycle("stall8");
        imem_ready = 1'b1;
        cycle("commit8");
        chk("retired3", retired, 32'd3);
        cycle("seqC");

        // Stalled jump ignored, then jmp beats br_taken
        imem_ready = 1'b0; jmp = 1'b1; jmp_target = 32'h100;
        br_taken = 1'b1; br_target = 32'h200;
        cycle("stall_jmp");
        imem_ready = 1'b1;
        cycle("jmp_vs_br");
        chk("jmp_dest", pc_r, 32'h100);
        idle_inputs();

        // Halt at 0x20, hold, resume fetches 0x24
        pc_r = 32'h20; halt_req = 1'b1; jmp = 1'b1; jmp_target = 32'h300;
        cycle("halt");
        idle_inputs();
        repeat (5) cycle("halted");
        resume = 1'b1;
        cycle("resume");
        resume = 1'b0;
        cycle("fetch24");
        resume = 1'b1;
        cycle("resume_in_fetch");
        resume = 1'b0;

        // Misaligned branch and jump targets
        pc_r = 32'h40; br_taken = 1'b1; br_target = 32'h102;
        cycle("mis_br");
        idle_inputs();
        cycle("after_mis_br");
        pc_r = 32'h80; jmp = 1'b1; jmp_target = 32'h203;
        cycle("mis_jmp");
        idle_inputs();
        cycle("after_mis_jmp");

        // PC wrap
        pc_r = 32'hFFFF_FFFC;
        cycle("wrap");

        // Reset during halt
        halt_req = 1'b1;
        cycle("halt2");
        halt_req = 1'b0;
        cycle("halted2");
        pulse_reset("rst_halt");
        cycle("boot2");
        cycle("fetch_rv2");

        // Reset during a stalled fetch
        imem_ready = 1'b0;
        cycle("stall_pre_rst");
        pulse_reset("rst_stall");
        imem_ready = 1'b1;
        cycle("boot3");
        cycle("fetch_rv3");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                idle_inputs();
                pulse_reset("rnd_rst");
            end
            imem_ready = ($urandom_range(0, 3) != 0);
            jmp        = ($urandom_range(0, 7) == 0);
            br_taken   = ($urandom_range(0, 3) == 0);
            halt_req   = ($urandom_range(0, 31) == 0);
            resume     = ($urandom_range(0, 3) == 0);
            jmp_target = $urandom();
            br_target  = $urandom();
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
